hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: per-stage register numbers, Tuse/Tnew
// hints and MDU control in; stall, forwarding selects and MDU status out.
interface hazard_ctrl_if;
    logic [4:0]  D_ReadA1, D_ReadA2;
    logic [1:0]  Tuse1, Tuse2;
    logic        MDUClass;
    logic [4:0]  E_ReadA1, E_ReadA2, E_WriteA;
    logic        E_RegWrite;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_ReadA2, M_WriteA;
    logic        M_RegWrite;
    logic [1:0]  M_Tnew;
    logic [4:0]  W_WriteA;
    logic        W_RegWrite;
    logic        MDUStart;
    logic        MDUType;

    logic        stall;
    logic [1:0]  Trans_grf_Sel1, Trans_grf_Sel2;
    logic [1:0]  Trans_ALUIn_Sel1, Trans_ALUIn_Sel2;
    logic [1:0]  Trans_MemRD_Sel;
    logic        MDUBusy;
    logic [15:0] stall_cnt;

    modport master (
        output D_ReadA1, D_ReadA2, Tuse1, Tuse2, MDUClass,
               E_ReadA1, E_ReadA2, E_WriteA, E_RegWrite, E_Tnew,
               M_ReadA2, M_WriteA, M_RegWrite, M_Tnew,
               W_WriteA, W_RegWrite, MDUStart, MDUType,
        input  stall, Trans_grf_Sel1, Trans_grf_Sel2,
               Trans_ALUIn_Sel1, Trans_ALUIn_Sel2, Trans_MemRD_Sel,
               MDUBusy, stall_cnt
    );

    modport slave (
        input  D_ReadA1, D_ReadA2, Tuse1, Tuse2, MDUClass,
               E_ReadA1, E_ReadA2, E_WriteA, E_RegWrite, E_Tnew,
               M_ReadA2, M_WriteA, M_RegWrite, M_Tnew,
               W_WriteA, W_RegWrite, MDUStart, MDUType,
        output stall, Trans_grf_Sel1, Trans_grf_Sel2,
               Trans_ALUIn_Sel1, Trans_ALUIn_Sel2, Trans_MemRD_Sel,
               MDUBusy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: Tuse/Tnew data stalls, MDU busy stalls,
// forwarding selects for D, E and M operands, and a saturating stall counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hif
);

    logic [3:0]  mdu_cnt;
    logic [1:0]  m_tnew_eff;
    logic        data_stall;
    logic        mdu_stall;
    logic        stall_int;
    logic [15:0] stall_cnt_q;

    function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] a);
        return we && (wa == a) && (a != 5'd0);
    endfunction

    // M_Tnew is still counted from E, so it is one cycle stale by the time the
    // instruction reaches M.
    assign m_tnew_eff = (hif.M_Tnew == 2'd0) ? 2'd0 : hif.M_Tnew - 2'd1;

    always_comb begin
        data_stall = 1'b0;
        if (hit(hif.E_RegWrite, hif.E_WriteA, hif.D_ReadA1) && (hif.Tuse1 < hif.E_Tnew))
            data_stall = 1'b1;
        if (hit(hif.M_RegWrite, hif.M_WriteA, hif.D_ReadA1) && (hif.Tuse1 < m_tnew_eff))
            data_stall = 1'b1;
        if (hit(hif.E_RegWrite, hif.E_WriteA, hif.D_ReadA2) && (hif.Tuse2 < hif.E_Tnew))
            data_stall = 1'b1;
        if (hit(hif.M_RegWrite, hif.M_WriteA, hif.D_ReadA2) && (hif.Tuse2 < m_tnew_eff))
            data_stall = 1'b1;
    end

    assign mdu_stall = hif.MDUClass && ((mdu_cnt != 4'd0) || hif.MDUStart);
    assign stall_int = data_stall || mdu_stall;

    always_comb begin
        hif.Trans_grf_Sel1 = 2'd0;
        if (hit(hif.E_RegWrite, hif.E_WriteA, hif.D_ReadA1) && (hif.E_Tnew == 2'd0))
            hif.Trans_grf_Sel1 = 2'd1;
        else if (hit(hif.M_RegWrite, hif.M_WriteA, hif.D_ReadA1) && (m_tnew_eff == 2'd0))
            hif.Trans_grf_Sel1 = 2'd2;

        hif.Trans_grf_Sel2 = 2'd0;
        if (hit(hif.E_RegWrite, hif.E_WriteA, hif.D_ReadA2) && (hif.E_Tnew == 2'd0))
            hif.Trans_grf_Sel2 = 2'd1;
        else if (hit(hif.M_RegWrite, hif.M_WriteA, hif.D_ReadA2) && (m_tnew_eff == 2'd0))
            hif.Trans_grf_Sel2 = 2'd2;

        hif.Trans_ALUIn_Sel1 = 2'd0;
        if (hit(hif.M_RegWrite, hif.M_WriteA, hif.E_ReadA1) && (m_tnew_eff == 2'd0))
            hif.Trans_ALUIn_Sel1 = 2'd1;
        else if (hit(hif.W_RegWrite, hif.W_WriteA, hif.E_ReadA1))
            hif.Trans_ALUIn_Sel1 = 2'd2;

        hif.Trans_ALUIn_Sel2 = 2'd0;
        if (hit(hif.M_RegWrite, hif.M_WriteA, hif.E_ReadA2) && (m_tnew_eff == 2'd0))
            hif.Trans_ALUIn_Sel2 = 2'd1;
        else if (hit(hif.W_RegWrite, hif.W_WriteA, hif.E_ReadA2))
            hif.Trans_ALUIn_Sel2 = 2'd2;

        hif.Trans_MemRD_Sel = 2'd0;
        if (hit(hif.W_RegWrite, hif.W_WriteA, hif.M_ReadA2))
            hif.Trans_MemRD_Sel = 2'd1;
    end

    // A new start reloads even while busy.
    always_ff @(posedge clk) begin
        if (reset)
            mdu_cnt <= 4'd0;
        else if (hif.MDUStart)
            mdu_cnt <= hif.MDUType ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (mdu_cnt != 4'd0)
            mdu_cnt <= mdu_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= 16'd0;
        else if (stall_int && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign hif.stall     = stall_int;
    assign hif.MDUBusy   = (mdu_cnt != 4'd0);
    assign hif.stall_cnt = stall_cnt_q;

endmodule
